// File: rtl/digest_target_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// digest_target_checker_pkg : shared SHA-256 word types, IV, FSM states, bswap
// Revision: 1.0
// ---------------------------------------------------------------------------
package digest_target_checker_pkg;

   localparam int WORD_W = 32;
   localparam int NWORDS = 8;
   localparam int REM_W  = 8;

   // Index k holds H<k>; shared with the H-register blocks.
   localparam logic [NWORDS-1:0][WORD_W-1:0] SHA256_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CMP_CONT = 2'd0,
      CMP_PASS = 2'd1,
      CMP_FAIL = 2'd2
   } cmp_res_t;

   function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/digest_target_checker_zero_prefix_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zero_prefix_cmp : checks one digest word against the remaining zero-bit budget
// Revision: 1.0
// ---------------------------------------------------------------------------
module zero_prefix_cmp
   import digest_target_checker_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [REM_W-1:0]  rem,
   input  logic              last,
   output cmp_res_t          result,
   output logic [REM_W-1:0]  next_rem
);

   localparam int SH_W = $clog2(WORD_W);

   logic [WORD_W-1:0] w_mask;

   // Ones in the top rem bits; only meaningful when rem < WORD_W.
   assign w_mask = ~({WORD_W{1'b1}} >> rem[SH_W-1:0]);

   always_comb begin
      result   = CMP_FAIL;
      next_rem = rem;
      if (rem == '0) begin
         result = CMP_PASS;
      end else if (rem >= REM_W'(WORD_W)) begin
         next_rem = rem - REM_W'(WORD_W);
         if (word != '0)
            result = CMP_FAIL;
         else if ((next_rem == '0) || last)
            result = CMP_PASS;
         else
            result = CMP_CONT;
      end else begin
         result = ((word & w_mask) == '0) ? CMP_PASS : CMP_FAIL;
      end
   end

endmodule
`default_nettype wire

// File: rtl/digest_target_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// digest_target_checker : captures a SHA-256 digest, scans it for leading zeros
// and reports winning nonces over a valid/ack handshake.  Revision: 1.0
// ---------------------------------------------------------------------------
module digest_target_checker
   import digest_target_checker_pkg::*;
#(
   parameter int NWORDS = 8,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              digest_valid,
   input  logic [31:0]       h0,
   input  logic [31:0]       h1,
   input  logic [31:0]       h2,
   input  logic [31:0]       h3,
   input  logic [31:0]       h4,
   input  logic [31:0]       h5,
   input  logic [31:0]       h6,
   input  logic [31:0]       h7,
   input  logic [31:0]       nonce_in,
   input  logic [7:0]        zbits,
   output logic              found_valid,
   output logic [31:0]       found_nonce,
   input  logic              found_ack,
   output logic              busy,
   output logic [CNT_W-1:0]  hash_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int K_W = $clog2(NWORDS);

   state_t                          r_state;
   logic [NWORDS-1:0][WORD_W-1:0]   r_value;
   logic [31:0]                     r_nonce;
   logic [REM_W-1:0]                r_rem;
   logic [K_W-1:0]                  r_k;
   logic                            r_found_valid;
   logic [31:0]                     r_found_nonce;
   logic [CNT_W-1:0]                r_hash_cnt;
   logic [CNT_W-1:0]                r_drop_cnt;

   logic [NWORDS-1:0][WORD_W-1:0]   w_captured;
   cmp_res_t                        w_res;
   logic [REM_W-1:0]                w_next_rem;

   // Word 7 ends up most significant, matching the miner's target comparison.
   assign w_captured = {bswap32(h7), bswap32(h6), bswap32(h5), bswap32(h4),
                        bswap32(h3), bswap32(h2), bswap32(h1), bswap32(h0)};

   zero_prefix_cmp u_cmp (
      .word     (r_value[r_k]),
      .rem      (r_rem),
      .last     (r_k == '0),
      .result   (w_res),
      .next_rem (w_next_rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_value       <= '0;
         r_nonce       <= '0;
         r_rem         <= '0;
         r_k           <= '0;
         r_found_valid <= 1'b0;
         r_found_nonce <= '0;
         r_hash_cnt    <= '0;
         r_drop_cnt    <= '0;
      end else begin
         // Any pulse outside IDLE is lost, including on the edge that leaves.
         if (digest_valid && (r_state != IDLE))
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);

         case (r_state)
            IDLE: begin
               if (digest_valid) begin
                  r_value    <= w_captured;
                  r_nonce    <= nonce_in;
                  r_rem      <= zbits;
                  r_k        <= K_W'(NWORDS - 1);
                  r_hash_cnt <= r_hash_cnt + CNT_W'(1);
                  r_state    <= SCAN;
               end
            end
            SCAN: begin
               case (w_res)
                  CMP_PASS: begin
                     r_found_valid <= 1'b1;
                     r_found_nonce <= r_nonce;
                     r_state       <= REPORT;
                  end
                  CMP_FAIL: begin
                     r_state <= IDLE;
                  end
                  default: begin
                     r_rem <= w_next_rem;
                     r_k   <= r_k - K_W'(1);
                  end
               endcase
            end
            REPORT: begin
               if (found_ack) begin
                  r_found_valid <= 1'b0;
                  r_state       <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign found_valid = r_found_valid;
   assign found_nonce = r_found_nonce;
   assign busy        = (r_state != IDLE);
   assign hash_cnt    = r_hash_cnt;
   assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire
